// File: rtl/serial_msg_receiver_pkg.sv
// ---------------------------------------------------------------------------
// serial_msg_receiver_pkg
//   Shared types and constants for the serial message receiver and its word
//   FIFO: receiver FSM state encoding, default baud/FIFO sizing, and the
//   word/byte geometry used for little-endian word assembly.
// ---------------------------------------------------------------------------
package serial_msg_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // 50 MHz clock / 115200 baud
    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int FIFO_DEPTH_DEF   = 4;

    localparam int WORD_W          = 32;
    localparam int BYTES_PER_WORD  = 4;
    localparam int BYTE_IDX_W      = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/msg_word_fifo.sv
// ---------------------------------------------------------------------------
// msg_word_fifo
//   Synchronous first-word fall-through FIFO of WIDTH-bit words.
//   Ports:
//     clk, n_reset   - clock (rising edge), asynchronous active-low reset
//     push/push_data - write strobe and word
//     pop            - read strobe, advances the head (ignored when empty)
//     full, empty    - occupancy status
//     count          - number of stored words (0..DEPTH)
//     head_data      - current head word, all zeros when empty
//   A push while full is accepted only if a pop happens in the same cycle.
//   DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module msg_word_fifo
    import serial_msg_receiver_pkg::*;
#(
    parameter  int WIDTH = WORD_W,
    parameter  int DEPTH = FIFO_DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // When full, a push only fits if the head leaves on the same edge.
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the empty gating below hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/serial_msg_receiver.sv
// ---------------------------------------------------------------------------
// serial_msg_receiver
//   8N1 UART receiver that assembles four accepted bytes (little-endian) into
//   32-bit words and queues them in a first-word fall-through FIFO.
//   Ports:
//     clk        - single clock, rising edge
//     n_reset    - asynchronous active-low reset
//     rx_serial  - asynchronous serial line, idle high, LSB first
//     receive    - pop strobe, one word per high cycle
//     clear_err  - clears the sticky overrun / frame_err flags
//     msg_data   - FIFO head word (zero when empty)
//     msg_valid  - FIFO non-empty
//     msg_count  - number of stored words
//     overrun    - sticky: a complete word was dropped (FIFO full)
//     frame_err  - sticky: a stop bit was sampled low
//     busy       - receiver FSM is not idle
// ---------------------------------------------------------------------------
module serial_msg_receiver
    import serial_msg_receiver_pkg::*;
#(
    parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter  int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              rx_serial,
    input  logic              receive,
    input  logic              clear_err,
    output logic [WORD_W-1:0] msg_data,
    output logic              msg_valid,
    output logic [CNT_W-1:0]  msg_count,
    output logic              overrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int                BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]            sync_q, sync_d;
    rx_state_e             state_q, state_d;
    logic                  armed_q, armed_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;

    logic              rx_s;
    logic              push;
    logic [WORD_W-1:0] push_word;
    logic              frame_set;
    logic              overrun_set;
    logic              fifo_full;
    logic              fifo_empty;

    // Two-flop synchronizer; rx_s is the only view of the line used below.
    assign sync_d = {sync_q[0], rx_serial};
    assign rx_s   = sync_q[1];

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        baud_d     = baud_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        push       = 1'b0;
        push_word  = word_q;
        frame_set  = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                // armed_q records that the line was seen high while idle, so
                // a line stuck low cannot retrigger frames.
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d   = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end

            START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    // High at mid start bit: glitch, drop silently.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d    = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            STOP: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
                        if (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
                            // Word complete: push on this same edge.
                            push       = 1'b1;
                            push_word  = word_d;
                            byte_idx_d = '0;
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end else begin
                        // Bad stop bit also throws away the partial word.
                        frame_set  = 1'b1;
                        byte_idx_d = '0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Mirrors the FIFO's drop condition: full and no pop this cycle.
    assign overrun_set = push && fifo_full && !receive;

    // Set wins over clear when both happen in the same cycle.
    always_comb begin
        overrun_d   = overrun_set ? 1'b1 : (clear_err ? 1'b0 : overrun_q);
        frame_err_d = frame_set   ? 1'b1 : (clear_err ? 1'b0 : frame_err_q);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            baud_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            armed_q     <= armed_d;
            baud_q      <= baud_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    msg_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (push),
        .push_data (push_word),
        .pop       (receive),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (msg_count),
        .head_data (msg_data)
    );

    assign msg_valid = !fifo_empty;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_msg_receiver.sv
`timescale 1ns/1ps
// Self-checking bench for serial_msg_receiver (CLKS_PER_BIT = 8, depth 4).
module tb_serial_msg_receiver;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk       = 1'b0;
    logic          n_reset   = 1'b0;
    logic          rx_serial = 1'b1;
    logic          receive   = 1'b0;
    logic          clear_err = 1'b0;
    logic [31:0]   msg_data;
    logic          msg_valid;
    logic [CW-1:0] msg_count;
    logic          overrun;
    logic          frame_err;
    logic          busy;

    serial_msg_receiver #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .rx_serial (rx_serial),
        .receive   (receive),
        .clear_err (clear_err),
        .msg_data  (msg_data),
        .msg_valid (msg_valid),
        .msg_count (msg_count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge monitor for busy falling / msg_valid rising.
    int   busy_fall_cyc  = -1;
    int   valid_rise_cyc = -1;
    logic prev_busy      = 1'b0;
    logic prev_valid     = 1'b0;
    always @(negedge clk) begin
        if (prev_busy && !busy)       busy_fall_cyc  = cyc;
        if (!prev_valid && msg_valid) valid_rise_cyc = cyc;
        prev_busy  = busy;
        prev_valid = msg_valid;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input int ec,
                             input logic [31:0] ed, input logic eo, input logic ef);
        check({tag, " valid"},     {31'd0, msg_valid}, {31'd0, ev});
        check({tag, " count"},     {29'd0, msg_count}, ec);
        check({tag, " data"},      msg_data, ed);
        check({tag, " overrun"},   {31'd0, overrun},   {31'd0, eo});
        check({tag, " frame_err"}, {31'd0, frame_err}, {31'd0, ef});
    endtask

    // Drive one 8N1 frame; pop_idx >= 0 raises receive for one cycle so that
    // it is sampled on edge start+pop_idx+1.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok,
                             input int pop_idx, output int start_cyc);
        int bit_i;
        start_cyc = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            @(posedge clk); #1;
            if (i == 0) start_cyc = cyc;
            bit_i = i / CPB;
            if (bit_i == 0)      rx_serial = 1'b0;
            else if (bit_i == 9) rx_serial = stop_ok;
            else                 rx_serial = b[bit_i-1];
            receive = (i == pop_idx);
        end
        @(posedge clk); #1;
        rx_serial = 1'b1;
        receive   = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        int sc;
        for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b1, -1, sc);
    endtask

    task automatic pop_pulse();
        @(posedge clk); #1; receive = 1'b1;
        @(posedge clk); #1; receive = 1'b0;
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1; clear_err = 1'b1;
        @(posedge clk); #1; clear_err = 1'b0;
    endtask

    typedef struct {
        logic        send;
        logic [7:0]  b;
        logic        stop_ok;
        logic        pop;
        logic        clr;
        logic        ev;
        int          ec;
        logic [31:0] ed;
        logic        eo;
        logic        ef;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic send, input logic [7:0] b, input logic stop_ok,
                       input logic pop, input logic clr, input logic ev, input int ec,
                       input logic [31:0] ed, input logic eo, input logic ef);
        vec_t v;
        v.send = send; v.b = b; v.stop_ok = stop_ok; v.pop = pop; v.clr = clr;
        v.ev = ev; v.ec = ec; v.ed = ed; v.eo = eo; v.ef = ef;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int off;
        int cnt;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset", 1'b0, 0, 32'h0, 1'b0, 1'b0);
        check("reset busy", {31'd0, busy}, 32'd0);
        n_reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // ---- table: word assembly, overrun, frame error ----
        add(1, 8'h78, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        add(1, 8'h56, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        add(1, 8'h34, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        add(1, 8'h12, 1, 0, 0, 1, 1, 32'h12345678, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 0, 0);   // pop on empty ignored
        for (int k = 1; k <= 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                cnt = (j == 3) ? k : k - 1;
                if (cnt > DEPTH) cnt = DEPTH;
                add(1, (j == 0) ? 8'(k) : 8'h00, 1, 0, 0, cnt > 0, cnt,
                    (cnt > 0) ? 32'h1 : 32'h0, (k == 5 && j == 3), 0);
            end
        end
        add(0, 8'h00, 1, 1, 0, 1, 3, 32'h2, 1, 0);
        add(0, 8'h00, 1, 1, 0, 1, 2, 32'h3, 1, 0);
        add(0, 8'h00, 1, 1, 0, 1, 1, 32'h4, 1, 0);
        add(0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 1, 0);
        add(0, 8'h00, 1, 0, 1, 0, 0, 32'h0, 0, 0);
        add(1, 8'h99, 1, 0, 0, 0, 0, 32'h0, 0, 0);   // partial byte, discarded
        add(1, 8'hAA, 0, 0, 0, 0, 0, 32'h0, 0, 1);   // bad stop bit
        add(1, 8'h01, 1, 0, 0, 0, 0, 32'h0, 0, 1);
        add(1, 8'h02, 1, 0, 0, 0, 0, 32'h0, 0, 1);
        add(1, 8'h03, 1, 0, 0, 0, 0, 32'h0, 0, 1);
        add(1, 8'h04, 1, 0, 0, 1, 1, 32'h04030201, 0, 1);
        add(0, 8'h00, 1, 0, 1, 1, 1, 32'h04030201, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].send) send_byte(vecs[i].b, vecs[i].stop_ok, -1, sc);
            if (vecs[i].pop)  pop_pulse();
            if (vecs[i].clr)  clr_pulse();
            repeat (2) @(posedge clk);
            @(negedge clk);
            check_all($sformatf("v%0d", i), vecs[i].ev, vecs[i].ec,
                      vecs[i].ed, vecs[i].eo, vecs[i].ef);
            #1;
        end

        // ---- msg_valid rises the cycle after the final stop sample ----
        send_byte(8'h11, 1'b1, -1, sc);
        send_byte(8'h22, 1'b1, -1, sc);
        send_byte(8'h33, 1'b1, -1, sc);
        valid_rise_cyc = -1;
        send_byte(8'h44, 1'b1, -1, sc);
        @(negedge clk);
        check("push_latency", valid_rise_cyc, busy_fall_cyc);
        check("latency word", msg_data, 32'h44332211);
        pop_pulse();

        // ---- 2-cycle glitch on idle line ----
        @(posedge clk); #1; rx_serial = 1'b0;
        repeat (2) @(posedge clk);
        #1; rx_serial = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("glitch busy", {31'd0, busy}, 32'd0);
        check_all("glitch", 1'b0, 0, 32'h0, 1'b0, 1'b0);
        #1;
        send_word(32'hA1B2C3D4);
        @(negedge clk);
        check("post-glitch word", msg_data, 32'hA1B2C3D4);
        pop_pulse();

        // ---- push and pop together while full ----
        for (int k = 1; k <= 4; k++) send_word(32'h10 * k);
        @(negedge clk);
        check("full count", {29'd0, msg_count}, 32'd4);
        #1;
        send_byte(8'h50, 1'b1, -1, sc);
        send_byte(8'h00, 1'b1, -1, sc);
        send_byte(8'h00, 1'b1, -1, sc);
        off = busy_fall_cyc - sc;   // stop-sample edge offset within a frame
        check("stop offset sane", {31'd0, (off >= 1 && off < 10 * CPB)}, 32'd1);
        send_byte(8'h00, 1'b1, off - 1, sc);
        @(negedge clk);
        check("simul count", {29'd0, msg_count}, 32'd4);
        check("simul overrun", {31'd0, overrun}, 32'd0);
        check("simul head", msg_data, 32'h20);
        for (int k = 3; k <= 5; k++) begin
            pop_pulse();
            @(negedge clk);
            check($sformatf("simul drain %0d", k), msg_data, 32'h10 * k);
        end
        pop_pulse();
        @(negedge clk);
        check("simul empty", {31'd0, msg_valid}, 32'd0);
        #1;

        // ---- reset in mid-frame ----
        send_word(32'h0BADF00D);
        send_byte(8'h55, 1'b0, -1, sc);
        send_byte(8'hAA, 1'b1, -1, sc);
        send_byte(8'hBB, 1'b1, -1, sc);
        @(negedge clk);
        check("pre-reset data", msg_data, 32'h0BADF00D);
        check("pre-reset ferr", {31'd0, frame_err}, 32'd1);
        @(posedge clk); #1; rx_serial = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        n_reset   = 1'b0;
        rx_serial = 1'b1;
        #1;
        check_all("in-reset", 1'b0, 0, 32'h0, 1'b0, 1'b0);
        check("in-reset busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send_word(32'hDEADBEEF);
        @(negedge clk);
        check_all("post-reset", 1'b1, 1, 32'hDEADBEEF, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
